// File: rtl/id_ex_stage_pkg.sv
// Shared hold-control/bus defines plus opcode constants and decode helpers for the ID/EX stage.
// The hold-field encodings below are common to every pipeline register driven by the hold controller.
`ifndef ID_EX_STAGE_DEFINES
`define ID_EX_STAGE_DEFINES
`define HOLD_CTRL_BUS 7:0
`define HOLD_NO       2'b00
`define HOLD_WAIT     2'b01
`define HOLD_FLUSH    2'b10
`define INST_BUS      31:0
`define INST_ADDR_BUS 31:0
`define NOP_INST_WORD 32'h00000013
`endif

package id_ex_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic logic writes_rd(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
            default:                      writes_rd = 1'b0;
        endcase
    endfunction

    // Only R/S/B formats actually read rs2; other formats reuse those bits for immediates.
    function automatic logic uses_rs2(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
            default:                       uses_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [31:0] inst);
        logic opc_ok;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: opc_ok = 1'b1;
            default:                                             opc_ok = 1'b0;
        endcase
        is_legal = opc_ok && (inst[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Combinational RV32I immediate builder; the result is registered by id_ex_stage.
module imm_gen
    import id_ex_stage_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [31:0] imm_o
);

    // Select the immediate format from the opcode.
    always_comb begin
        imm_o = 32'd0;
        case (inst_i[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            OPC_STORE:                     imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            OPC_BRANCH:                    imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                                                    inst_i[30:25], inst_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:            imm_o = {inst_i[31:12], 12'd0};
            OPC_JAL:                       imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                                                    inst_i[20], inst_i[30:21], 1'b0};
            default:                       imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register with hold/flush handling and load-use stall request.
// Optional feature macro: ID_EX_ILLEGAL_TRAP_EN (adds registered illegal_o).
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int          HOLD_IDX = 2,
    parameter logic [31:0] NOP_INST = `NOP_INST_WORD
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [`INST_BUS]      inst_i,
    input  logic [`INST_ADDR_BUS] inst_addr_i,
    input  logic [`HOLD_CTRL_BUS] hold_i,
    input  logic [31:0]           rs1_data_i,
    input  logic [31:0]           rs2_data_i,
    output logic [4:0]            rs1_addr_o,
    output logic [4:0]            rs2_addr_o,
    output logic                  stall_req_o,
    output logic [31:0]           inst_o,
    output logic [31:0]           inst_addr_o,
    output logic [31:0]           op1_o,
    output logic [31:0]           op2_o,
    output logic [31:0]           imm_o,
    output logic [4:0]            rd_addr_o,
    output logic                  rd_we_o,
    output logic                  mem_rd_o,
    output logic                  valid_o
`ifdef ID_EX_ILLEGAL_TRAP_EN
    ,
    output logic                  illegal_o
`endif
);

    logic [1:0]  hold_field_s;
    logic [31:0] imm_s;
    logic        illegal_s;
    logic [31:0] inst_d, inst_q, inst_addr_d, inst_addr_q;
    logic [31:0] op1_d, op1_q, op2_d, op2_q, imm_d, imm_q;
    logic [4:0]  rd_d, rd_q;
    logic        rd_we_d, rd_we_q, mem_rd_d, mem_rd_q, valid_d, valid_q;
`ifdef ID_EX_ILLEGAL_TRAP_EN
    logic        illegal_d, illegal_q;
    assign illegal_s = !is_legal(inst_i);
    assign illegal_o = illegal_q;
`else
    assign illegal_s = 1'b0;
`endif

    imm_gen u_imm_gen (
        .inst_i (inst_i),
        .imm_o  (imm_s)
    );

    assign hold_field_s = hold_i[HOLD_IDX*2 +: 2];
    assign rs1_addr_o   = inst_i[19:15];
    assign rs2_addr_o   = inst_i[24:20];

    // A load in EX whose rd feeds the instruction now in ID cannot forward in time.
    assign stall_req_o = valid_q & mem_rd_q & (rd_q != 5'd0) &
                         ((rd_q == rs1_addr_o) |
                          (uses_rs2(inst_i[6:0]) & (rd_q == rs2_addr_o)));

    // Next-state selection: flush > wait > stall bubble > capture.
    always_comb begin
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        imm_d       = imm_q;
        rd_d        = rd_q;
        rd_we_d     = rd_we_q;
        mem_rd_d    = mem_rd_q;
        valid_d     = valid_q;
`ifdef ID_EX_ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        if ((hold_field_s == `HOLD_FLUSH) || ((hold_field_s == `HOLD_NO) && stall_req_o)) begin
            inst_d      = NOP_INST;
            inst_addr_d = inst_addr_i;
            op1_d       = 32'd0;
            op2_d       = 32'd0;
            imm_d       = 32'd0;
            rd_d        = 5'd0;
            rd_we_d     = 1'b0;
            mem_rd_d    = 1'b0;
            valid_d     = 1'b0;
`ifdef ID_EX_ILLEGAL_TRAP_EN
            illegal_d   = 1'b0;
`endif
        end else if (hold_field_s == `HOLD_NO) begin
            inst_d      = inst_i;
            inst_addr_d = inst_addr_i;
            op1_d       = rs1_data_i;
            op2_d       = rs2_data_i;
            imm_d       = imm_s;
            rd_d        = inst_i[11:7];
            rd_we_d     = writes_rd(inst_i[6:0]) & (inst_i[11:7] != 5'd0) & ~illegal_s;
            mem_rd_d    = (inst_i[6:0] == OPC_LOAD) & ~illegal_s;
            valid_d     = 1'b1;
`ifdef ID_EX_ILLEGAL_TRAP_EN
            illegal_d   = illegal_s;
`endif
        end else begin
            valid_d     = valid_q;
        end
    end

    // ID/EX register bank; reset leaves a non-valid NOP in the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q      <= NOP_INST;
            inst_addr_q <= 32'd0;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            imm_q       <= 32'd0;
            rd_q        <= 5'd0;
            rd_we_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            valid_q     <= 1'b0;
`ifdef ID_EX_ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
            mem_rd_q    <= mem_rd_d;
            valid_q     <= valid_d;
`ifdef ID_EX_ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    assign inst_o      = inst_q;
    assign inst_addr_o = inst_addr_q;
    assign op1_o       = op1_q;
    assign op2_o       = op2_q;
    assign imm_o       = imm_q;
    assign rd_addr_o   = rd_q;
    assign rd_we_o     = rd_we_q;
    assign mem_rd_o    = mem_rd_q;
    assign valid_o     = valid_q;

endmodule
